// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: decodes SPI command words and shares a
// single-port RAM with a local host, round-robin.
module spi_mem_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 host_rvalid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 err_clr,
  output logic                 err_seq,
  output logic                 err_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [1:0] C_WA = 2'b00;
  localparam logic [1:0] C_WR = 2'b01;
  localparam logic [1:0] C_RA = 2'b10;
  localparam logic [1:0] C_RD = 2'b11;

  state_t state, state_nxt;

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] rx_addr;
  logic [DATA_W-1:0]    rx_byte;

  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 rd_armed;

  logic                 pend_v, pend_we;
  logic [ADDR_SIZE-1:0] pend_addr;
  logic [DATA_W-1:0]    pend_data;

  logic                 op_we, op_host;
  logic [ADDR_SIZE-1:0] op_addr;
  logic [DATA_W-1:0]    op_wdata;
  logic                 last_host;

  logic spi_sel, host_sel, slot_free;
  logic ld_wa, ld_ra, is_wr, is_rd;
  logic take_wr, take_rd, new_ovf, new_seq;

  assign cmd     = rx_data[9:8];
  assign rx_addr = rx_data[ADDR_SIZE-1:0];
  assign rx_byte = rx_data[DATA_W-1:0];

  // On a tie the requester that did not own the port last wins.
  assign spi_sel  = (state == IDLE) & pend_v
                  & (~host_req | last_host);
  assign host_sel = (state == IDLE) & host_req & ~spi_sel;

  assign slot_free = ~pend_v | spi_sel;

  assign ld_wa   = rx_valid & (cmd == C_WA);
  assign ld_ra   = rx_valid & (cmd == C_RA);
  assign is_wr   = rx_valid & (cmd == C_WR);
  assign is_rd   = rx_valid & (cmd == C_RD);
  assign take_wr = is_wr & slot_free;
  assign take_rd = is_rd & rd_armed & slot_free;
  assign new_ovf = (is_wr | (is_rd & rd_armed)) & ~slot_free;
  assign new_seq = is_rd & ~rd_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_armed <= 1'b0;
    end else begin
      unique case (1'b1)
        ld_wa: wr_addr <= rx_addr;
        ld_ra: begin
          rd_addr  <= rx_addr;
          rd_armed <= 1'b1;
        end
        take_wr: wr_addr <= wr_addr + 1'b1;
        take_rd: rd_addr <= rd_addr + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (take_wr) begin
      pend_v    <= 1'b1;
      pend_we   <= 1'b1;
      pend_addr <= wr_addr;
      pend_data <= rx_byte;
    end else if (take_rd) begin
      pend_v    <= 1'b1;
      pend_we   <= 1'b0;
      pend_addr <= rd_addr;
      pend_data <= '0;
    end else if (spi_sel) begin
      pend_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (spi_sel || host_sel) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = op_we ? IDLE : CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_we     <= 1'b0;
      op_host   <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      last_host <= 1'b1;
    end else if (spi_sel) begin
      op_we     <= pend_we;
      op_host   <= 1'b0;
      op_addr   <= pend_addr;
      op_wdata  <= pend_data;
      last_host <= 1'b0;
    end else if (host_sel) begin
      op_we     <= host_we;
      op_host   <= 1'b1;
      op_addr   <= host_addr;
      op_wdata  <= host_wdata;
      last_host <= 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    host_gnt  = 1'b0;
    if (state == ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = op_we;
      mem_addr  = op_addr;
      mem_wdata = op_wdata;
      host_gnt  = op_host;
    end
  end

  assign busy = (state != IDLE) | pend_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      tx_valid    <= 1'b0;
      host_rvalid <= 1'b0;
      if (state == CAPTURE) begin
        if (op_host) begin
          host_rdata  <= mem_rdata;
          host_rvalid <= 1'b1;
        end else begin
          tx_data  <= mem_rdata;
          tx_valid <= 1'b1;
        end
      end
    end
  end

  // A fresh error in the clearing cycle must survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_seq <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      err_seq <= new_seq | (err_seq & ~err_clr);
      err_ovf <= new_ovf | (err_ovf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: vector table, directed corner
// sequences and a random run against a reference model.
module tb_spi_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       err_clr, err_seq, err_ovf, busy;
  logic       ram_load = 1'b0;
  logic [7:0] ram [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.ADDR_SIZE(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .err_clr(err_clr), .err_seq(err_seq),
    .err_ovf(err_ovf), .busy(busy)
  );

  function automatic logic [7:0] pat(int i);
    return 8'(i * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rx_valid = 0; rx_data = '0; err_clr = 0;
    host_req = 0; host_we = 0;
    host_addr = '0; host_wdata = '0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_txv"}, tx_valid, 0);
    chk({nm, "_txd"}, tx_data, 0);
    chk({nm, "_gnt"}, host_gnt, 0);
    chk({nm, "_hrd"}, host_rdata, 0);
    chk({nm, "_hrv"}, host_rvalid, 0);
    chk({nm, "_en"}, mem_en, 0);
    chk({nm, "_we"}, mem_we, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_wd"}, mem_wdata, 0);
    chk({nm, "_eseq"}, err_seq, 0);
    chk({nm, "_eovf"}, err_ovf, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1; ram_load = 1;
    cyc();
    ram_load = 0;
    cyc();
    chk_zero("reset");
    rst = 0;
  endtask

  task automatic send(input logic [9:0] w);
    rx_valid = 1; rx_data = w;
  endtask

  typedef struct {
    logic       rxv;
    logic [9:0] rxd;
    logic       en, we;
    logic [7:0] addr, wd;
    logic       txv;
    logic [7:0] txd;
    logic       bsy;
  } vec_t;

  function automatic vec_t mk(logic rxv, logic [9:0] rxd,
    logic en, logic we, logic [7:0] a, logic [7:0] d,
    logic txv, logic [7:0] txd, logic b);
    vec_t v;
    v.rxv = rxv; v.rxd = rxd; v.en = en; v.we = we;
    v.addr = a; v.wd = d; v.txv = txv; v.txd = txd;
    v.bsy = b;
    return v;
  endfunction

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  // reference model state for the random run
  logic [7:0] sh [256];
  logic [7:0] m_wa, m_ra, pa, pd;
  bit         m_armed, pv, pwe, m_last_host, m_es, m_eo;
  int         ng, lg;
  acc_t       e_acc [int];
  logic [7:0] e_tx [int];
  logic [7:0] e_hr [int];
  bit         e_gnt [int];

  task automatic run_table();
    vec_t tv [16];
    tv[0]  = mk(1, 10'h010, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    tv[1]  = mk(1, 10'h1A5, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    tv[2]  = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    tv[3]  = mk(1, 10'h15A, 1, 1, 8'h10, 8'hA5, 0, 8'h00, 1);
    tv[4]  = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    tv[5]  = mk(0, 10'h000, 1, 1, 8'h11, 8'h5A, 0, 8'h00, 1);
    tv[6]  = mk(1, 10'h210, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    tv[7]  = mk(1, 10'h300, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    tv[8]  = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    tv[9]  = mk(0, 10'h000, 1, 0, 8'h10, 8'h00, 0, 8'h00, 1);
    tv[10] = mk(1, 10'h300, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    tv[11] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 1);
    tv[12] = mk(0, 10'h000, 1, 0, 8'h11, 8'h00, 0, 8'h00, 1);
    tv[13] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    tv[14] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 8'h5A, 0);
    tv[15] = mk(0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl%0d_en", i), mem_en, tv[i].en);
      chk($sformatf("tbl%0d_we", i), mem_we, tv[i].we);
      chk($sformatf("tbl%0d_addr", i), mem_addr, tv[i].addr);
      if (!tv[i].en || tv[i].we)
        chk($sformatf("tbl%0d_wd", i), mem_wdata, tv[i].wd);
      chk($sformatf("tbl%0d_txv", i), tx_valid, tv[i].txv);
      if (tv[i].txv)
        chk($sformatf("tbl%0d_txd", i), tx_data, tv[i].txd);
      chk($sformatf("tbl%0d_busy", i), busy, tv[i].bsy);
      rx_valid = tv[i].rxv;
      rx_data  = tv[i].rxd;
      cyc();
    end
    chk("tbl_ram10", ram[8'h10], 8'hA5);
    chk("tbl_ram11", ram[8'h11], 8'h5A);
  endtask

  task automatic run_err_seq();
    do_reset();
    send(10'h300);
    cyc();
    rx_valid = 0;
    chk("eseq_set", err_seq, 1);
    for (int i = 0; i < 5; i++) begin
      chk("eseq_no_en", mem_en, 0);
      chk("eseq_no_tx", tx_valid, 0);
      chk("eseq_busy", busy, 0);
      cyc();
    end
    err_clr = 1;
    cyc();
    err_clr = 0;
    chk("eseq_clr", err_seq, 0);
    err_clr = 1; send(10'h3AB);
    cyc();
    err_clr = 0; rx_valid = 0;
    chk("eseq_wins", err_seq, 1);
    err_clr = 1;
    cyc();
    err_clr = 0;
    chk("eseq_clr2", err_seq, 0);
  endtask

  task automatic run_tie();
    do_reset();
    send(10'h021);
    cyc();
    send(10'h188);
    cyc();
    rx_valid = 0;
    chk("tie_gnt_c2", host_gnt, 0);
    host_req = 1; host_we = 1;
    host_addr = 8'h20; host_wdata = 8'h77;
    cyc();
    chk("tie_spi_en", mem_en, 1);
    chk("tie_spi_addr", mem_addr, 8'h21);
    chk("tie_spi_wd", mem_wdata, 8'h88);
    chk("tie_gnt_c3", host_gnt, 0);
    cyc();
    chk("tie_gnt_c4", host_gnt, 0);
    cyc();
    chk("tie_gnt_c5", host_gnt, 1);
    chk("tie_host_addr", mem_addr, 8'h20);
    chk("tie_host_wd", mem_wdata, 8'h77);
    host_req = 0;
    cyc();
    chk("tie_gnt_c6", host_gnt, 0);
    chk("tie_ram20", ram[8'h20], 8'h77);
    chk("tie_ram21", ram[8'h21], 8'h88);
  endtask

  task automatic run_wrap_ovf();
    do_reset();
    send(10'h0FF); cyc();
    send(10'h111); cyc();
    rx_valid = 0; cyc();
    chk("wrap_addr0", mem_addr, 8'hFF);
    chk("wrap_wd0", mem_wdata, 8'h11);
    send(10'h122); cyc();
    rx_valid = 0; cyc();
    chk("wrap_addr1", mem_addr, 8'h00);
    chk("wrap_wd1", mem_wdata, 8'h22);
    host_req = 1; host_we = 1;
    host_addr = 8'h40; host_wdata = 8'h99;
    cyc(); cyc();
    chk("ovf_h1_gnt", host_gnt, 1);
    host_req = 0;
    cyc();
    send(10'h131); cyc();
    send(10'h132);
    host_req = 1; host_we = 1;
    host_addr = 8'h41; host_wdata = 8'hAA;
    cyc();
    chk("ovf_w1_addr", mem_addr, 8'h01);
    chk("ovf_w1_gnt", host_gnt, 0);
    send(10'h133); cyc();
    rx_valid = 0;
    chk("ovf_flag", err_ovf, 1);
    cyc();
    chk("ovf_h2_gnt", host_gnt, 1);
    chk("ovf_h2_addr", mem_addr, 8'h41);
    host_req = 0;
    cyc(); cyc();
    chk("ovf_w2_addr", mem_addr, 8'h02);
    chk("ovf_w2_wd", mem_wdata, 8'h32);
    send(10'h144); cyc();
    rx_valid = 0; cyc();
    chk("ovf_w4_addr", mem_addr, 8'h03);
    chk("ovf_w4_wd", mem_wdata, 8'h44);
    cyc();
    chk("ovf_ramff", ram[8'hFF], 8'h11);
    chk("ovf_ram00", ram[8'h00], 8'h22);
    chk("ovf_ram01", ram[8'h01], 8'h31);
    chk("ovf_ram02", ram[8'h02], 8'h32);
    chk("ovf_ram03", ram[8'h03], 8'h44);
    chk("ovf_ram40", ram[8'h40], 8'h99);
    chk("ovf_ram41", ram[8'h41], 8'hAA);
    chk("ovf_sticky", err_ovf, 1);
    chk("ovf_noseq", err_seq, 0);
  endtask

  task automatic run_rst_mid();
    do_reset();
    send(10'h230); cyc();
    send(10'h300); cyc();
    rx_valid = 0; cyc();
    chk("rmid_acc_en", mem_en, 1);
    chk("rmid_acc_addr", mem_addr, 8'h30);
    cyc();
    chk("rmid_cap_busy", busy, 1);
    chk("rmid_cap_en", mem_en, 0);
    rst = 1;
    cyc();
    chk_zero("rmid");
    rst = 0;
    host_req = 1; host_we = 0; host_addr = 8'h30;
    cyc();
    chk("rmid_h_gnt", host_gnt, 1);
    chk("rmid_h_addr", mem_addr, 8'h30);
    chk("rmid_txv1", tx_valid, 0);
    host_req = 0;
    cyc();
    chk("rmid_hrv_early", host_rvalid, 0);
    chk("rmid_txv2", tx_valid, 0);
    cyc();
    chk("rmid_hrv", host_rvalid, 1);
    chk("rmid_hrd", host_rdata, pat(8'h30));
    chk("rmid_txv3", tx_valid, 0);
  endtask

  task automatic run_random(input int n);
    logic [1:0] cm;
    logic [7:0] pl;
    bit         gs, gh, nes, neo;
    acc_t       a;
    do_reset();
    for (int i = 0; i < 256; i++) sh[i] = pat(i);
    m_wa = 0; m_ra = 0; m_armed = 0; pv = 0; pwe = 0;
    pa = 0; pd = 0; m_last_host = 1; m_es = 0; m_eo = 0;
    ng = 0; lg = -1;
    for (int c = 0; c < n; c++) begin
      if (e_acc.exists(c)) begin
        a = e_acc[c];
        chk("rnd_en", mem_en, 1);
        chk("rnd_we", mem_we, a.we);
        chk("rnd_addr", mem_addr, a.addr);
        if (a.we) chk("rnd_wd", mem_wdata, a.data);
      end else begin
        chk("rnd_en0", mem_en, 0);
        chk("rnd_we0", mem_we, 0);
        chk("rnd_addr0", mem_addr, 0);
        chk("rnd_wd0", mem_wdata, 0);
      end
      chk("rnd_gnt", host_gnt, e_gnt.exists(c));
      chk("rnd_txv", tx_valid, e_tx.exists(c));
      if (e_tx.exists(c)) chk("rnd_txd", tx_data, e_tx[c]);
      chk("rnd_hrv", host_rvalid, e_hr.exists(c));
      if (e_hr.exists(c)) chk("rnd_hrd", host_rdata, e_hr[c]);
      chk("rnd_eseq", err_seq, m_es);
      chk("rnd_eovf", err_ovf, m_eo);
      chk("rnd_busy", busy, (c > lg && c < ng) || pv);
      // drive this cycle
      if (host_req && e_gnt.exists(c)) begin
        host_req = 0;
      end else if (!host_req && $urandom_range(0, 2) == 0) begin
        host_req   = 1;
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 8'($urandom_range(0, 15));
        host_wdata = 8'($urandom);
      end
      cm = 2'($urandom_range(0, 3));
      pl = (cm[0] == 0) ? 8'($urandom_range(0, 15))
                        : 8'($urandom);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = {cm, pl};
      err_clr  = ($urandom_range(0, 24) == 0);
      // model: arbitration for the port
      gs = 0; gh = 0;
      if (c >= ng) begin
        if (pv && (!host_req || m_last_host)) gs = 1;
        else if (host_req) gh = 1;
      end
      if (gs || gh) begin
        a.we   = gs ? pwe : host_we;
        a.addr = gs ? pa : host_addr;
        a.data = gs ? pd : host_wdata;
        e_acc[c+1] = a;
        if (a.we) sh[a.addr] = a.data;
        else if (gh) e_hr[c+3] = sh[a.addr];
        else e_tx[c+3] = sh[a.addr];
        if (gh) e_gnt[c+1] = 1;
        if (gs) pv = 0;
        lg = c;
        ng = c + (a.we ? 2 : 3);
        m_last_host = gh;
      end
      // model: command decode
      nes = 0; neo = 0;
      if (rx_valid) begin
        case (cm)
          2'b00: m_wa = pl;
          2'b10: begin m_ra = pl; m_armed = 1; end
          2'b01: begin
            if (!pv) begin
              pv = 1; pwe = 1; pa = m_wa; pd = pl;
              m_wa = m_wa + 8'd1;
            end else neo = 1;
          end
          default: begin
            if (!m_armed) nes = 1;
            else if (!pv) begin
              pv = 1; pwe = 0; pa = m_ra; pd = 0;
              m_ra = m_ra + 8'd1;
            end else neo = 1;
          end
        endcase
      end
      if (err_clr) begin m_es = 0; m_eo = 0; end
      if (nes) m_es = 1;
      if (neo) m_eo = 1;
      cyc();
    end
    idle_in();
  endtask

  initial begin
    run_table();
    run_err_seq();
    run_tie();
    run_wrap_ovf();
    run_rst_mid();
    run_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Sits between the SPI slave's parallel side (rx_data/rx_valid, tx_data/tx_valid) and a single-port synchronous RAM.
- Decodes the 10-bit SPI command words into address-register loads, RAM writes and RAM reads.
- Shares the RAM port with a local host requester using round-robin arbitration.
- Returns SPI read data on tx_data/tx_valid and host read data on host_rdata/host_rvalid.

Parameters:
ADDR_SIZE, 8, RAM address width; rx_data[7:0] carries the address, so only 8 is supported.
DATA_W, 8, RAM data width; must match the tx_data width.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
rx_data  in  10  SPI word; [9:8] command, [7:0] payload
rx_valid  in  1  one-cycle pulse; rx_data is valid
tx_data  out  8  SPI read data
tx_valid  out  1  one-cycle pulse; tx_data is valid
host_req  in  1  host access request; held until host_gnt
host_we  in  1  1 = write, 0 = read; stable while host_req is high
host_addr  in  ADDR_SIZE  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  one-cycle pulse in the host's ACCESS cycle
host_rdata  out  DATA_W  host read data
host_rvalid  out  1  one-cycle pulse; host_rdata is valid
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_SIZE  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data; valid the cycle after an enabled read
err_clr  in  1  clears the sticky error flags
err_seq  out  1  sticky: read-data command received with no read address loaded
err_ovf  out  1  sticky: SPI memory command dropped because the pending slot was full
busy  out  1  high when FSM is not IDLE or spi_pend = 1

Behaviour:
- Reset: all outputs 0; wr_addr = 0, rd_addr = 0; rd_armed = 0; spi_pend = 0; FSM = IDLE; last_owner = HOST, so SPI wins the first tie. Reset mid-operation abandons it: no tx_valid, no host_rvalid.
- Command decode happens on the edge where rx_valid = 1:
  - 00: wr_addr <= rx_data[7:0]. No RAM access.
  - 10: rd_addr <= rx_data[7:0]; rd_armed <= 1. No RAM access.
  - 01: pending slot captures {write, wr_addr, rx_data[7:0]}; wr_addr increments, 8'hFF wraps to 8'h00.
  - 11: if rd_armed, pending slot captures {read, rd_addr}; rd_addr increments with the same wrap; rx_data[7:0] is ignored (dummy byte). If not rd_armed: err_seq <= 1, no slot, no response.
- Pending slot (spi_pend) accepts a new op if it is empty, or if it is granted on that same edge.
  - Otherwise the new op is dropped, err_ovf <= 1, and wr_addr/rd_addr stay unchanged.
  - Commands 00/10 are never dropped.
  - Later 00/10 commands never alter an op already in the slot.
- FSM states IDLE, ACCESS, CAPTURE:
  - IDLE: if spi_pend or host_req, pick an owner and latch the op (host fields are sampled here); go to ACCESS. Granting SPI clears spi_pend.
  - ACCESS: mem_en = 1; mem_we/mem_addr/mem_wdata come from the latched op. host_gnt = 1 if the owner is HOST. On a write go to IDLE; on a read go to CAPTURE.
  - CAPTURE: mem_rdata is registered into tx_data or host_rdata; go to IDLE. tx_valid or host_rvalid is high for one cycle, the cycle after CAPTURE.
- mem_* outputs are 0 outside ACCESS.
- Arbitration: if only one requester is present, it wins. If both are present, the one that is not last_owner wins. last_owner updates on each grant.
- Latency:
  - SPI read: rx_valid at cycle T gives tx_valid at T+4 when uncontended.
  - SPI write: RAM write in cycle T+2.
  - Host read: host_req seen in IDLE at cycle H gives gnt at H+1 and rvalid at H+3.
  - Throughput is one write per 2 cycles and one read per 3 cycles.
- err_clr clears both sticky flags. If err_clr and a new error occur in the same cycle, the error wins.

Test Plan:
- rx 00_10, rx 01_A5, rx 01_5A -> RAM[0x10] = A5, RAM[0x11] = 5A; mem_we pulses 2 cycles after each 01 word.
- rx 10_10, then rx 11_00 twice -> tx_valid each time, tx_data A5 then 5A; first tx_valid exactly 4 cycles after the 11 word's rx_valid.
- 11_00 immediately after reset -> err_seq = 1, no mem_en, no tx_valid; err_clr pulse -> err_seq = 0.
- host_req write (0x20, 0x77) raised in the same cycle spi_pend is set for write (0x21, 0x88) -> SPI granted first, host next; RAM[0x20] = 77, RAM[0x21] = 88; host_gnt is exactly 1 cycle.
- wr_addr = 0xFF, two 01 writes -> addresses 0xFF then 0x00; three 01 words back-to-back while host holds the port -> third word dropped, err_ovf = 1.
- Reset asserted during CAPTURE of an SPI read -> no tx_valid; all outputs 0; FSM in IDLE next cycle.
